// File: rtl/json_command_parser.sv
// Byte-stream parser for {"T":n,"L":n,"R":n}\n motor commands.
// Produces a one-cycle cmd_valid on commit or parse_err on abort.
module json_command_parser #(
  parameter int VAL_W        = 16,
  parameter int MAX_DIGITS   = 4,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             cmd_valid,
  output logic [VAL_W-1:0] cmd_t,
  output logic [VAL_W-1:0] cmd_l,
  output logic [VAL_W-1:0] cmd_r,
  output logic             parse_err,
  output logic             busy
);

  localparam int AW = VAL_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KOPEN, S_KEY, S_KCLOSE, S_COLON, S_VALUE, S_END
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       key_q, key_d;
  logic [2:0]       seen_q, seen_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [VAL_W-1:0] sh_t_q, sh_t_d, sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [VAL_W-1:0] cmd_t_q, cmd_t_d, cmd_l_q, cmd_l_d;
  logic [VAL_W-1:0] cmd_r_q, cmd_r_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             parse_err_q, parse_err_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             err, commit, is_key, is_dig, live;
  logic [1:0]       ksel;
  logic [VAL_W-1:0] val;

  always_comb begin
    ksel   = 2'd0;
    is_key = 1'b1;
    case (rx_data)
      "T":     ksel = 2'd0;
      "L":     ksel = 2'd1;
      "R":     ksel = 2'd2;
      default: is_key = 1'b0;
    endcase
  end

  assign is_dig = (rx_data >= "0") && (rx_data <= "9");
  assign live   = rx_valid && (rx_data != 8'h20) && (rx_data != 8'h0D);
  assign val    = neg_q ? (~acc_q[VAL_W-1:0] + VAL_W'(1))
                        : acc_q[VAL_W-1:0];

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    seen_d      = seen_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    sh_t_d      = sh_t_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    cmd_t_d     = cmd_t_q;
    cmd_l_d     = cmd_l_q;
    cmd_r_d     = cmd_r_q;
    cmd_valid_d = 1'b0;
    parse_err_d = 1'b0;
    err         = 1'b0;
    commit      = 1'b0;
    tmo_d       = (rx_valid || state_q == S_IDLE) ? '0 : tmo_q + TW'(1);

    if (live) begin
      case (state_q)
        S_IDLE:   if (rx_data == "{") state_d = S_KOPEN;
        S_KOPEN:  if (rx_data == "\"") state_d = S_KEY; else err = 1'b1;
        S_KEY:
          if (is_key && !seen_q[ksel]) begin
            key_d   = ksel;
            state_d = S_KCLOSE;
          end else err = 1'b1;
        S_KCLOSE: if (rx_data == "\"") state_d = S_COLON; else err = 1'b1;
        S_COLON:
          if (rx_data == ":") begin
            state_d = S_VALUE;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
          end else err = 1'b1;
        S_VALUE:
          if (rx_data == "-" && cnt_q == '0 && !neg_q) begin
            neg_d = 1'b1;
          end else if (is_dig) begin
            if (cnt_q == CW'(MAX_DIGITS)) err = 1'b1;
            else begin
              acc_d = acc_q * AW'(10) + AW'(rx_data[3:0]);
              cnt_d = cnt_q + CW'(1);
            end
          end else if ((rx_data == "," || rx_data == "}") && cnt_q != '0) begin
            case (key_q)
              2'd0:    sh_t_d = val;
              2'd1:    sh_l_d = val;
              default: sh_r_d = val;
            endcase
            seen_d[key_q] = 1'b1;
            state_d = (rx_data == ",") ? S_KOPEN : S_END;
          end else err = 1'b1;
        S_END:
          if (rx_data == "\n" && &seen_q) commit = 1'b1;
          else err = 1'b1;
        default: err = 1'b1;
      endcase
    end else if (!rx_valid && state_q != S_IDLE
                 && tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
      err = 1'b1;
    end

    if (commit) begin
      cmd_t_d     = sh_t_q;
      cmd_l_d     = sh_l_q;
      cmd_r_d     = sh_r_q;
      cmd_valid_d = 1'b1;
      seen_d      = '0;
      state_d     = S_IDLE;
    end
    // A stray '{' both aborts the old message and opens the new one
    if (err) begin
      parse_err_d = 1'b1;
      seen_d      = '0;
      state_d     = (rx_valid && rx_data == "{") ? S_KOPEN : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      seen_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      sh_t_q      <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      cmd_t_q     <= '0;
      cmd_l_q     <= '0;
      cmd_r_q     <= '0;
      cmd_valid_q <= 1'b0;
      parse_err_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      seen_q      <= seen_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      sh_t_q      <= sh_t_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      cmd_t_q     <= cmd_t_d;
      cmd_l_q     <= cmd_l_d;
      cmd_r_q     <= cmd_r_d;
      cmd_valid_q <= cmd_valid_d;
      parse_err_q <= parse_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign parse_err = parse_err_q;
  assign cmd_t     = cmd_t_q;
  assign cmd_l     = cmd_l_q;
  assign cmd_r     = cmd_r_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_json_command_parser.sv
// Directed bench for json_command_parser with an expected-command queue.
// Pulses and held outputs are checked on the falling edge after each byte.
module tb_json_command_parser;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid, parse_err, busy;
  logic [15:0] cmd_t, cmd_l, cmd_r;

  typedef struct {
    int t;
    int l;
    int r;
  } trip_t;

  trip_t sbq[$];
  trip_t cur;
  int    checks = 0;
  int    errors = 0;

  json_command_parser #(
    .VAL_W(16), .MAX_DIGITS(4), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_t(cmd_t), .cmd_l(cmd_l),
    .cmd_r(cmd_r), .parse_err(parse_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("cmd_t", $signed(cmd_t), cur.t);
    chk("cmd_l", $signed(cmd_l), cur.l);
    chk("cmd_r", $signed(cmd_r), cur.r);
  endtask

  // kind: 0 = no pulse, 1 = cmd_valid, 2 = parse_err
  task automatic send(byte b, int kind);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("cmd_valid", cmd_valid, kind == 1);
    chk("parse_err", parse_err, kind == 2);
    if (cmd_valid === 1'b1) begin
      if (sbq.size() == 0) chk("sb_underflow", 1, 0);
      else cur = sbq.pop_front();
    end
    chk_outs();
  endtask

  task automatic send_str(string s, int last);
    int n;
    n = s.len();
    for (int i = 0; i < n; i++) send(s[i], (i == n - 1) ? last : 0);
  endtask

  task automatic msg(string s, int t, int l, int r);
    trip_t e;
    e.t = t;
    e.l = l;
    e.r = r;
    sbq.push_back(e);
    send_str(s, 1);
  endtask

  initial begin
    int hit;
    cur.t = 0;
    cur.l = 0;
    cur.r = 0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_parse_err", parse_err, 0);
    chk("rst_busy", busy, 0);
    chk_outs();
    rst = 1'b0;
    @(negedge clk);

    msg("{\"T\":11,\"L\":164,\"R\":164}\n", 11, 164, 164);

    send_str("{\"R\":-50, \"T\":1,\"L\":-50}", 0);
    send(8'h0D, 0);
    sbq.push_back('{1, -50, -50});
    send("\n", 1);

    send_str("{\"T\":11,\"X", 2);
    send_str("5}\n", 0);

    send_str("{\"T\":1{", 2);
    msg("\"T\":2,\"L\":3,\"R\":4}\n", 2, 3, 4);

    send_str("{\"T\":12345", 2);
    send("\n", 0);
    send_str("{\"T\":11,\"L\":1}\n", 2);

    msg("{\"T\":9999,\"L\":-9999,\"R\":0}\n", 9999, -9999, 0);

    send_str("{\"T\":1,\"T", 2);
    send_str("{\"T\":,", 2);
    send_str("{\"T\":--", 2);
    send_str("xyz}\n", 0);

    msg("{\"L\":7,\"R\":8,\"T\":9}\n", 9, 7, 8);
    msg("{\"T\":-1,\"R\":-2,\"L\":-3}\n", -1, -3, -2);

    send_str("{\"T\":1", 0);
    chk("tmo_busy_pre", busy, 1);
    hit = 0;
    for (int k = 1; k <= TMO + 3 && hit == 0; k++) begin
      @(negedge clk);
      chk("tmo_no_cmd", cmd_valid, 0);
      if (parse_err === 1'b1) hit = k;
    end
    chk("tmo_cycle", hit, TMO);
    chk("tmo_busy_post", busy, 0);
    chk_outs();
    @(negedge clk);

    send_str("{\"T\":5,\"L\":6", 0);
    rst = 1'b1;
    @(negedge clk);
    cur.t = 0;
    cur.l = 0;
    cur.r = 0;
    chk("rst_mid_cmd_valid", cmd_valid, 0);
    chk("rst_mid_parse_err", parse_err, 0);
    chk("rst_mid_busy", busy, 0);
    chk_outs();
    rst = 1'b0;
    @(negedge clk);
    send_str("\"R\":7}\n", 0);

    msg("{\"T\":3,\"L\":4,\"R\":5}\n", 3, 4, 5);
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
